inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage of the single-issue MIPS-subset datapath. It holds the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction and PC+4 into an IF/ID pipeline register for the decode stage. It accepts stall and branch-redirect requests from decode and stops fetching after a programmed end address.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- END_PC, 32'h0000_001C, address of the last instruction to fetch; fetch stops after it
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse, leaves IDLE and begins fetching
- stall  input  1  decode hazard; hold PC and IF/ID register
- br_taken  input  1  decode resolved a taken branch/jump this cycle
- br_target  input  32  redirect address, valid when br_taken=1
- imem_addr  output  32  byte address to instruction memory (= pc)
- imem_inst  input  32  instruction word returned combinationally for imem_addr
- if_id_inst  output  32  registered instruction for decode
- if_id_pc4  output  32  registered PC+4 of that instruction
- if_id_valid  output  1  if_id_inst is a real instruction (0 = bubble)
- halted  output  1  fetch has finished at END_PC

## Operation
- FSM states: IDLE, RUN, DRAIN, HALT.
- IDLE: pc holds RESET_PC, no capture, if_id_valid=0. start=1 -> RUN.
- RUN, per rising edge, priority order: br_taken > stall > normal.
  - br_taken=1: pc <= br_target; if_id_valid <= 0 (flush the wrong-path word); ignores stall same cycle.
  - stall=1 (br_taken=0): pc, if_id_inst, if_id_pc4, if_id_valid all hold.
  - normal: if_id_inst <= imem_inst; if_id_pc4 <= pc+4; if_id_valid <= 1; pc <= pc+4.
  - normal capture with pc==END_PC -> DRAIN (pc still advances to END_PC+4, not used).
- DRAIN: no new capture. If stall=1 hold everything; else if_id_valid <= 0 and -> HALT. br_taken=1 in DRAIN: pc <= br_target, if_id_valid <= 0, -> RUN (a branch in the last instruction still redirects).
- HALT: sticky until rst; halted=1; if_id_valid=0; start, stall, br_taken ignored.
- start outside IDLE ignored.
- PC arithmetic: 32-bit unsigned, pc+4 wraps modulo 2^32; bits [1:0] of br_target forced to 0 when loaded.
- imem_addr = pc always (combinational from the register).

## Timing
- Reset (async assert, any state, mid-stall or mid-branch included): pc=RESET_PC, if_id_inst=0, if_id_pc4=0, if_id_valid=0, halted=0, state=IDLE. Deassertion synchronous to clk in integrating logic.
- Fetch latency: instruction at pc appears on if_id_inst 1 cycle after the edge at which pc was presented; one instruction per cycle with no stall.
- Branch penalty: 1 bubble (if_id_valid=0 for one cycle after br_taken edge), target instruction valid on the following edge.
- start edge -> first capture on the next edge (IDLE->RUN costs 1 cycle).
- halted rises on the edge that clears the last valid if_id word.

## Structure
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, HALT=2'd3), PC_INC=32'd4, instruction width constant.
- One natural sub-module: if_id_reg (32+32+1-bit register with enable=~stall and synchronous clear=flush, async rst). Next-PC mux and FSM remain in inst_fetch.

## Test plan
- Reset then start, no stall/branch, 8-word program: if_id_pc4 sequence 4,8,...,32 with valid=1, then valid=0 and halted=1 one cycle after pc4=32.
- stall held 3 cycles while if_id_pc4=12: pc stays 12, if_id outputs unchanged for 3 cycles, resume capturing pc=12 word.
- br_taken with br_target=32'h14 while pc=24: next cycle pc=20, if_id_valid=0; following cycle if_id_pc4=24, valid=1.
- br_taken and stall same cycle: redirect taken, bubble inserted, stall ignored.
- Branch in DRAIN (last word at 28, br_target=4): returns to RUN, halted stays 0, fetch resumes at 4.
- rst asserted mid-RUN asynchronously: outputs read 0/RESET_PC immediately without a clock edge, state IDLE; start needed to refetch.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

  localparam int          INST_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag.
// A clear takes priority over a load.
module inst_fetch_if_id_reg
  import inst_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [INST_W-1:0] d_inst,
  input  logic [31:0]       d_pc4,
  output logic [INST_W-1:0] q_inst,
  output logic [31:0]       q_pc4,
  output logic              q_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_inst  <= '0;
      q_pc4   <= '0;
      q_valid <= 1'b0;
    end else if (clr) begin
      q_inst  <= '0;
      q_pc4   <= '0;
      q_valid <= 1'b0;
    end else if (en) begin
      q_inst  <= d_inst;
      q_pc4   <= d_pc4;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch FSM and
// the IF/ID register feeding decode.
//
// state | meaning
// IDLE  | pc parked at RESET_PC, waiting for start
// RUN   | one fetch per cycle; branch > stall > sequential
// DRAIN | last word (END_PC) held in IF/ID until decode consumes it
// HALT  | fetch finished, sticky until rst
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] END_PC   = 32'h0000_001C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  output logic [31:0]       imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic [INST_W-1:0] if_id_inst,
  output logic [31:0]       if_id_pc4,
  output logic              if_id_valid,
  output logic              halted
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        load, flush;

  assign pc_plus4  = pc_q + PC_INC;
  assign imem_addr = pc_q;
  assign halted    = (state_q == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!br_taken && !stall && pc_q == END_PC) state_d = DRAIN;
      DRAIN: begin
        if (br_taken)    state_d = RUN;
        else if (!stall) state_d = HALT;
      end
      default: state_d = state_q;
    endcase
  end

  // A taken branch in DRAIN still redirects: the last word may be a jump.
  always_comb begin
    pc_d  = pc_q;
    load  = 1'b0;
    flush = 1'b0;
    case (state_q)
      RUN: begin
        if (br_taken) begin
          pc_d  = align_word(br_target);
          flush = 1'b1;
        end else if (!stall) begin
          pc_d = pc_plus4;
          load = 1'b1;
        end
      end
      DRAIN: begin
        if (br_taken) begin
          pc_d  = align_word(br_target);
          flush = 1'b1;
        end else if (!stall) begin
          flush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  inst_fetch_if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .en      (load),
    .clr     (flush),
    .d_inst  (imem_inst),
    .d_pc4   (pc_plus4),
    .q_inst  (if_id_inst),
    .q_pc4   (if_id_pc4),
    .q_valid (if_id_valid)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a vector table for the straight-line program
// and hand-written sequences for stall, branch, drain and async reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, br_taken;
  logic [31:0] br_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hACE0_0000 | (a & 32'h0000_FFFF);
  endfunction

  always_comb imem_inst = mem_word(imem_addr);

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_addr   (imem_addr),
    .imem_inst   (imem_inst),
    .if_id_inst  (if_id_inst),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  typedef struct {
    logic        start;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] pc4;
    logic        halted;
  } vec_t;

  vec_t tbl[12];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic expect_out(input string nm, input logic [31:0] pc, input logic valid,
                            input logic [31:0] pc4, input logic hlt);
    cmp({nm, "/pc"}, imem_addr, pc);
    cmp({nm, "/valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    cmp({nm, "/halted"}, {31'd0, halted}, {31'd0, hlt});
    if (valid) begin
      cmp({nm, "/pc4"}, if_id_pc4, pc4);
      cmp({nm, "/inst"}, if_id_inst, mem_word(pc4 - 32'd4));
    end
  endtask

  // Drive one cycle's inputs, clock it, sample 1 time unit after the edge.
  task automatic tick(input logic s, input logic st, input logic br, input logic [31:0] tgt);
    start     = s;
    stall     = st;
    br_taken  = br;
    br_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    start = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic run_normal(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;

    //          start stall br  tgt            pc     valid pc4    halted
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h04, 1'b1, 32'h04, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h08, 1'b1, 32'h08, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0C, 1'b1, 32'h0C, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h10, 1'b1, 32'h10, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h14, 1'b1, 32'h14, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h18, 1'b1, 32'h18, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h1C, 1'b1, 32'h1C, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h20, 1'b1, 32'h20, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h20, 1'b0, 32'h00, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h4,  32'h20, 1'b0, 32'h00, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    expect_out("reset", 32'h0, 1'b0, 32'h0, 1'b0);
    cmp("reset/inst", if_id_inst, 32'h0);
    cmp("reset/pc4", if_id_pc4, 32'h0);

    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].start, tbl[i].stall, tbl[i].br, tbl[i].tgt);
      expect_out($sformatf("vec%0d", i), tbl[i].pc, tbl[i].valid, tbl[i].pc4, tbl[i].halted);
    end

    // Stall for three cycles with pc4=12, then resume with the pc=12 word.
    apply_reset();
    tick(1, 0, 0, 0);
    run_normal(3);
    expect_out("pre_stall", 32'h0C, 1'b1, 32'h0C, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 0);
      expect_out($sformatf("stall%0d", k), 32'h0C, 1'b1, 32'h0C, 1'b0);
    end
    tick(0, 0, 0, 0);
    expect_out("post_stall", 32'h10, 1'b1, 32'h10, 1'b0);

    // Branch at pc=24 to 0x14: one bubble, then the target word.
    run_normal(2);
    expect_out("pre_br", 32'h18, 1'b1, 32'h18, 1'b0);
    tick(0, 0, 1, 32'h14);
    expect_out("br_bubble", 32'h14, 1'b0, 32'h0, 1'b0);
    tick(0, 0, 0, 0);
    expect_out("br_target", 32'h18, 1'b1, 32'h18, 1'b0);

    // Branch with stall in the same cycle; low target bits are dropped.
    tick(0, 1, 1, 32'h0B);
    expect_out("br_stall_bubble", 32'h08, 1'b0, 32'h0, 1'b0);
    tick(0, 0, 0, 0);
    expect_out("br_stall_target", 32'h0C, 1'b1, 32'h0C, 1'b0);

    // Reach DRAIN, branch back to 4, refetch, DRAIN again with a stall, then halt.
    run_normal(5);
    expect_out("drain1", 32'h20, 1'b1, 32'h20, 1'b0);
    tick(0, 0, 1, 32'h4);
    expect_out("drain_br", 32'h04, 1'b0, 32'h0, 1'b0);
    tick(0, 0, 0, 0);
    expect_out("drain_br_tgt", 32'h08, 1'b1, 32'h08, 1'b0);
    run_normal(6);
    expect_out("drain2", 32'h20, 1'b1, 32'h20, 1'b0);
    tick(0, 1, 0, 0);
    expect_out("drain_stall", 32'h20, 1'b1, 32'h20, 1'b0);
    tick(0, 0, 0, 0);
    expect_out("drain_halt", 32'h20, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-RUN, sampled before any clock edge.
    apply_reset();
    tick(1, 0, 0, 0);
    run_normal(2);
    expect_out("pre_arst", 32'h08, 1'b1, 32'h08, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect_out("arst", 32'h0, 1'b0, 32'h0, 1'b0);
    cmp("arst/inst", if_id_inst, 32'h0);
    cmp("arst/pc4", if_id_pc4, 32'h0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick(0, 0, 0, 0);
    expect_out("arst_idle", 32'h0, 1'b0, 32'h0, 1'b0);
    tick(1, 0, 0, 0);
    expect_out("arst_start", 32'h0, 1'b0, 32'h0, 1'b0);
    tick(0, 0, 0, 0);
    expect_out("arst_refetch", 32'h04, 1'b1, 32'h04, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
